mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the data cache. It turns the registered memory-op fields into a valid/ready cache request with byte enables and replicated store data, and raises `dcache_stall` until the access completes. It formats load data (byte/half extraction, sign/zero extension) for the MEM/WB register. It also holds a completed result if the pipeline is frozen by another stall source, so an access is never issued twice.

## Interface
Parameters:
- none (widths fixed: 32-bit address/data, RV32)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- riscv_start, riscv_done  in  1 each  core running when start && !done
- md_alu_stall  in  1  other stall source freezing EX/MEM
- ex_mem_alu_result  in  32  effective address
- ex_mem_mem_read, ex_mem_mem_write  in  1 each  op select (never both)
- ex_mem_mem_size  in  2  00 byte, 01 half, 10 word
- ex_mem_mem_unsigned  in  1  zero-extend loads
- ex_mem_mem_write_data  in  32  store source (low bits significant)
- dc_req_valid  out  1  request valid
- dc_req_we  out  1  1 = store
- dc_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dc_req_be  out  4  byte enables
- dc_req_wdata  out  32  lane-replicated store data
- dc_req_ready  in  1  cache accepts request
- dc_resp_valid  in  1  load data valid
- dc_resp_rdata  in  32  raw load word
- dcache_stall  out  1  hold IF..EX/MEM this cycle
- mem_load_data  out  32  formatted load result
- mem_misaligned  out  1  misalignment flag (see Configuration)

## Operation
- Op pending = running && (mem_read || mem_write) && state ∈ {IDLE, REQ, WAIT_RESP}.
- FSM states:
  - IDLE: with an op present, drive dc_req_valid combinationally.
    - Store handshake (valid && ready): done → IDLE, or → DONE if md_alu_stall.
    - Load handshake: → WAIT_RESP.
    - No ready: → REQ.
  - REQ: hold request stable until ready; then the same exits as IDLE.
  - WAIT_RESP: dc_req_valid=0. On dc_resp_valid, capture formatted data into load_q; → IDLE, or → DONE if md_alu_stall.
  - DONE: the access is complete and the op is not re-issued. mem_load_data=load_q, dcache_stall=0. → IDLE on the first cycle with md_alu_stall=0 (the pipeline advances at that edge).
- dcache_stall = op pending && !(store handshake this cycle) && !(state==WAIT_RESP && dc_resp_valid).
- mem_load_data:
  - In the WAIT_RESP response cycle it is formatted dc_resp_rdata, combinational.
  - In DONE it is load_q.
  - Otherwise it is 0.
- Byte enables and store data:
  - sb: be = 4'b0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - sh: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wd[15:0]}}.
  - sw: be = 4'b1111; wdata = wd.
  - Loads: be reflects the size; we = 0.
- Load format:
  - Byte lane is selected by addr[1:0], half lane by addr[1].
  - Sign-extend unless mem_unsigned. Word loads ignore mem_unsigned.
- mem_size = 11 is treated as word.
- Not running (start=0 or done=1): no new request from IDLE, dcache_stall=0. An access already in REQ/WAIT_RESP still completes its handshake; the result is then discarded and the FSM goes to IDLE.
- Reset, including mid-access: state → IDLE. A dc_resp_valid arriving while in IDLE is ignored.

## Timing
- Reset values: state IDLE, load_q 0, dc_req_valid 0, dcache_stall 0, mem_load_data 0, mem_misaligned 0. dc_req_* data outputs are 0 while valid is 0.
- Store with dc_req_ready=1 in the first cycle: 0 stall cycles.
- Load: minimum 1 stall cycle (request at cycle N, response earliest N+1). Stall cycles = (cycles waiting for ready) + (response latency).
- Request fields are stable while dc_req_valid && !dc_req_ready.
- dc_resp_valid in the same cycle as the load handshake is illegal (the cache contract forbids it).

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned access is not issued and raises no stall.
  - mem_misaligned=1 combinationally for that cycle; load data = 0.
- Not defined:
  - No check; mem_misaligned is tied to 0.
  - Low address bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0) before computing be/lanes, and the access proceeds.

## Structure
- Package riscv_lsu_pkg:
  - size encodings MEM_B/MEM_H/MEM_W
  - FSM state enum (IDLE, REQ, WAIT_RESP, DONE)
  - function computing byte enables
- Sub-module lsu_load_format: purely combinational; inputs (rdata, addr[1:0], size, unsigned) → 32-bit result; used for both the combinational path and the load_q capture.

## Test plan
- sw to 0x100 with data 0xDEADBEEF, ready=1 → be=1111, wdata=0xDEADBEEF, addr=0x100, dcache_stall never 1.
- sb to 0x103 with data 0x000000A5, ready low for 2 cycles → dcache_stall high 2 cycles with request held stable, then be=1000, wdata=0xA5A5A5A5.
- lb from 0x101 with rdata=0x0000_8000, resp after 3 cycles → stall 3 cycles, mem_load_data=0xFFFFFF80. lbu from the same address → 0x00000080.
- lh from 0x102 with rdata=0xFFFF1234: resp arrives while md_alu_stall=1 → DONE, mem_load_data stays 0xFFFFFFFF, exactly one dc_req handshake total.
- Reset asserted while in WAIT_RESP, followed by a late dc_resp_valid → state IDLE, no capture, all outputs 0.
- lw from 0x102: with LSU_MISALIGN_TRAP_EN → no dc_req_valid, mem_misaligned=1, data 0. Without it → request addr 0x100, be=1111.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// size encodings, FSM state type, cache request bundle and the byte-enable helper.
package riscv_lsu_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dc_req_t;

  // Byte enables for an access; size 11 falls through to word.
  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      MEM_B:   return 4'b0001 << addr_lo;
      MEM_H:   return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load data formatter: selects the byte/half lane from a raw cache word and
// sign- or zero-extends it. Purely combinational.
module lsu_load_format
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        mem_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select plus extension; word loads pass through untouched.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_B:   result = {{24{byte_v[7] & ~mem_unsigned}}, byte_v};
      MEM_H:   result = {{16{half_v[15] & ~mem_unsigned}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Issues valid/ready data-cache requests from the
// EX/MEM fields, stalls the front of the pipe until the access completes, formats
// load data, and parks a finished result in DONE while another stall source holds
// the pipe so the access is not issued twice.
// Optional: LSU_MISALIGN_TRAP_EN -- flag misaligned half/word accesses instead of
// issuing them; when undefined the low address bits are forced to alignment.
module mem_access_unit
  import riscv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_start,
  input  logic        riscv_done,
  input  logic        md_alu_stall,
  input  logic [31:0] ex_mem_alu_result,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [1:0]  ex_mem_mem_size,
  input  logic        ex_mem_mem_unsigned,
  input  logic [31:0] ex_mem_mem_write_data,
  output logic        dc_req_valid,
  output logic        dc_req_we,
  output logic [31:0] dc_req_addr,
  output logic [3:0]  dc_req_be,
  output logic [31:0] dc_req_wdata,
  input  logic        dc_req_ready,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_resp_rdata,
  output logic        dcache_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_misaligned
);

  lsu_state_e  state, state_d;
  logic [31:0] load_q, load_d;

  logic        running, has_op, is_half, is_word;
  logic        misaligned, mis_flag;
  logic [1:0]  addr_lo;
  logic        req_active, handshake, store_hs, load_hs, resp_now;
  logic [31:0] fmt_data;
  dc_req_t     req;

  assign running = riscv_start & ~riscv_done & ~reset;
  assign has_op  = ex_mem_mem_read | ex_mem_mem_write;
  assign is_half = (ex_mem_mem_size == MEM_H);
  assign is_word = ex_mem_mem_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned accesses are reported, never issued.
  assign misaligned = (is_half & ex_mem_alu_result[0]) |
                      (is_word & (ex_mem_alu_result[1:0] != 2'b00));
  assign addr_lo    = ex_mem_alu_result[1:0];
`else
  // No trap: quietly snap the address to natural alignment.
  assign misaligned = 1'b0;
  assign addr_lo    = is_word ? 2'b00 :
                      is_half ? {ex_mem_alu_result[1], 1'b0} : ex_mem_alu_result[1:0];
`endif

  // Only a fresh op from IDLE can be misaligned; REQ/WAIT_RESP were already accepted.
  assign mis_flag   = running & has_op & (state == IDLE) & misaligned;

  // REQ keeps its request up even if the core stops, so the handshake finishes.
  assign req_active = ~reset & (((state == IDLE) & running & has_op & ~misaligned) |
                                (state == REQ));
  assign handshake  = req_active & dc_req_ready;
  assign store_hs   = handshake & ex_mem_mem_write;
  assign load_hs    = handshake & ex_mem_mem_read;
  assign resp_now   = ~reset & (state == WAIT_RESP) & dc_resp_valid;

  lsu_load_format u_fmt (
    .rdata        (dc_resp_rdata),
    .addr_lo      (addr_lo),
    .size         (ex_mem_mem_size),
    .mem_unsigned (ex_mem_mem_unsigned),
    .result       (fmt_data)
  );

  // Request bundle; all fields read as zero when no request is active.
  always_comb begin
    req = '0;
    if (req_active) begin
      req.valid = 1'b1;
      req.we    = ex_mem_mem_write;
      req.addr  = {ex_mem_alu_result[31:2], 2'b00};
      req.be    = lsu_byte_en(ex_mem_mem_size, addr_lo);
      case (ex_mem_mem_size)
        MEM_B:   req.wdata = {4{ex_mem_mem_write_data[7:0]}};
        MEM_H:   req.wdata = {2{ex_mem_mem_write_data[15:0]}};
        default: req.wdata = ex_mem_mem_write_data;
      endcase
      if (!ex_mem_mem_write) req.wdata = '0;
    end
  end

  assign dc_req_valid = req.valid;
  assign dc_req_we    = req.we;
  assign dc_req_addr  = req.addr;
  assign dc_req_be    = req.be;
  assign dc_req_wdata = req.wdata;

  assign dcache_stall   = running & has_op & (state != DONE) & ~mis_flag &
                          ~store_hs & ~resp_now;
  assign mem_load_data  = resp_now ? fmt_data :
                          (~reset & (state == DONE)) ? load_q : 32'd0;
  assign mem_misaligned = mis_flag;

  // Next state and load_q update; DONE only entered while still running and frozen.
  always_comb begin
    state_d = state;
    load_d  = load_q;
    case (state)
      IDLE, REQ: begin
        if (req_active) begin
          if (store_hs) begin
            state_d = (running & md_alu_stall) ? DONE : IDLE;
            if (running & md_alu_stall) load_d = '0;
          end else if (load_hs) begin
            state_d = WAIT_RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      WAIT_RESP: begin
        if (dc_resp_valid) begin
          if (running) load_d = fmt_data;
          state_d = (running & md_alu_stall) ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!md_alu_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      state  <= state_d;
      load_q <= load_d;
    end
  end

endmodule
